// File: rtl/signed_divider_seq.sv
// signed_divider_seq: sequential sign-magnitude divider, restoring shift-subtract, one quotient bit per clock
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       launch request, accepted in IDLE or FINISH
//   A, B        dividend / divisor, sign-magnitude (sign in MSB)
//   busy        high while the iteration is in progress
//   done        one-cycle pulse when results update
//   Quotient    signed quotient, sign-magnitude, truncating
//   Remainder   signed remainder, sign-magnitude, takes the dividend sign
//   div_by_zero divisor magnitude was zero; held with the results
module signed_divider_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             div_by_zero
);
   localparam int M  = WIDTH - 1;
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] M_C = CW'(M);
   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
   state_t           state_q, state_d;
   // aq holds the dividend magnitude; quotient bits shift in from the bottom as dividend bits leave the top
   logic [M-1:0]     aq_q, aq_d, b_q, b_d;
   logic [M:0]       rem_q, rem_d, rem_sh, rem_sub;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sa_q, sa_d, sb_q, sb_d, ge;
   logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;
   logic             dbz_q, dbz_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         aq_q    <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         aq_q    <= aq_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dbz_q   <= dbz_d;
      end
   end
   always_comb begin
      state_d = state_q;
      aq_d    = aq_q;
      b_d     = b_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dbz_d   = dbz_q;
      rem_sh  = (rem_q << 1) | {{M{1'b0}}, aq_q[M-1]};
      rem_sub = rem_sh - {1'b0, b_q};
      ge      = rem_sh >= {1'b0, b_q};
      case (state_q)
         IDLE, FINISH: begin
            state_d = start ? CALC : IDLE;
            if (start) begin
               aq_d  = A[M-1:0];
               b_d   = B[M-1:0];
               // a negative zero operand is folded to +0 here
               sa_d  = A[M] & (|A[M-1:0]);
               sb_d  = B[M] & (|B[M-1:0]);
               rem_d = '0;
               cnt_d = M_C;
            end
         end
         CALC: begin
            if (b_q == '0) begin
               state_d = FINISH;
               dbz_d   = 1'b1;
               quo_d   = '0;
               rmd_d   = {sa_q, aq_q};
            end else begin
               rem_d = ge ? rem_sub : rem_sh;
               aq_d  = {aq_q[M-2:0], ge};
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state_d = FINISH;
                  dbz_d   = 1'b0;
                  quo_d   = {(sa_q ^ sb_q) & (|aq_d), aq_d};
                  rmd_d   = {sa_q & (|rem_d[M-1:0]), rem_d[M-1:0]};
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign busy        = state_q == CALC;
   assign done        = state_q == FINISH;
   assign Quotient    = quo_q;
   assign Remainder   = rmd_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_signed_divider_seq.sv
// tb_signed_divider_seq: scoreboard bench for signed_divider_seq with directed and random operands
module tb_signed_divider_seq;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] A = '0, B = '0;
   logic       busy, done, div_by_zero;
   logic [7:0] Quotient, Remainder;
   int         checks = 0, passes = 0;
   logic [16:0] sbq[$];
   bit         prev_done = 1'b0;

   signed_divider_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
      int am, bm, qm, rm;
      bit sa, sb;
      am = int'(a[6:0]);
      bm = int'(b[6:0]);
      sa = a[7] && am != 0;
      sb = b[7] && bm != 0;
      if (bm == 0) return {1'b1, 8'h00, sa, 7'(am)};
      qm = am / bm;
      rm = am % bm;
      return {1'b0, (sa ^ sb) && qm != 0, 7'(qm), sa && rm != 0, 7'(rm)};
   endfunction

   always @(negedge clk) begin
      logic [16:0] e;
      if (rst_n && done) begin
         checks++;
         if (prev_done) $display("FAIL done_pulse: done high two cycles in a row");
         else passes++;
         checks++;
         if (sbq.size() == 0) $display("FAIL unexpected_done: got Q=%h R=%h dbz=%b, required no result", Quotient, Remainder, div_by_zero);
         else begin
            e = sbq.pop_front();
            if ({div_by_zero, Quotient, Remainder} !== e)
               $display("FAIL result: got dbz=%b Q=%h R=%h, required dbz=%b Q=%h R=%h",
                        div_by_zero, Quotient, Remainder, e[16], e[15:8], e[7:0]);
            else passes++;
         end
      end
      prev_done = rst_n && done;
   end

   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit hold);
      int n, nb, lat;
      logic [16:0] e;
      n = 0;
      while (busy && n < 50) begin @(negedge clk); n++; end
      e = model(a, b);
      lat = e[16] ? 1 : 7;
      start = 1'b1; A = a; B = b;
      sbq.push_back(e);
      n = 0; nb = 0;
      do begin
         @(negedge clk);
         n++;
         if (!hold) start = 1'b0;
         if (busy) nb++;
      end while (!done && n < 50);
      checks++;
      if (!done || n - 1 != lat) $display("FAIL latency A=%h B=%h: got %0d cycles, required %0d", a, b, n - 1, lat);
      else passes++;
      checks++;
      if (nb != lat) $display("FAIL busy_cycles A=%h B=%h: got %0d, required %0d", a, b, nb, lat);
      else passes++;
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({busy, done, Quotient, Remainder, div_by_zero} !== '0)
         $display("FAIL %s: got busy=%b done=%b Q=%h R=%h dbz=%b, required all 0", name, busy, done, Quotient, Remainder, div_by_zero);
      else passes++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int ndone;
      bit hold, prev_hold;
      logic [7:0] a, b;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;
      do_op(8'h07, 8'h82, 1'b0);
      do_op(8'h87, 8'h02, 1'b0);
      do_op(8'h85, 8'h05, 1'b0);
      do_op(8'h93, 8'h80, 1'b0);
      do_op(8'h7F, 8'h01, 1'b1);
      do_op(8'h7F, 8'h01, 1'b0);
      do_op(8'h80, 8'h05, 1'b0);
      do_op(8'h00, 8'h00, 1'b0);
      // aborted operation: start ignored mid-flight, then async reset
      @(negedge clk);
      start = 1'b1; A = 8'h7F; B = 8'h03;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 start = 1'b1; A = 8'h01;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_zero("async_reset");
      ndone = 0;
      repeat (12) begin @(negedge clk); if (done) ndone++; end
      checks++;
      if (ndone != 0) $display("FAIL aborted_done: got %0d pulses, required 0", ndone);
      else passes++;
      rst_n = 1'b1;
      do_op(8'h7F, 8'h03, 1'b0);
      prev_hold = 1'b0;
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         if ($urandom_range(0, 6) == 0) b[6:0] = 7'd0;
         if ($urandom_range(0, 9) == 0) a[6:0] = 7'd0;
         hold = ($urandom_range(0, 3) == 0) && i < 39;
         if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
         do_op(a, b, hold);
         prev_hold = hold;
      end
      start = 1'b0;
      repeat (12) @(negedge clk);
      checks++;
      if (sbq.size() != 0) $display("FAIL pending_results: got %0d outstanding, required 0", sbq.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
